// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the unified-memory arbiter between fetch and load/store.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_RSP  = 2'd2
  } state_e;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_LS = 1'b1
  } owner_e;

  localparam int unsigned ADDR_W_DEF     = 32;
  localparam int unsigned DATA_W_DEF     = 32;
  localparam int unsigned STARVE_MAX_DEF = 4;

  // Wide enough for any byte-enable width in use; narrowed with a cast at the point of use.
  localparam int unsigned           BE_MAX_W = 64;
  localparam logic [BE_MAX_W-1:0]   BE_ALL   = '1;

endpackage

// File: rtl/mem_arb_prio.sv
// Load/store-first priority pick with a saturating counter that bounds fetch starvation.
module mem_arb_prio
  import mem_arb_pkg::*;
#(
  parameter int unsigned STARVE_MAX = STARVE_MAX_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic arb_en,
  input  logic if_req,
  input  logic ls_req,
  output logic sel_if,
  output logic sel_ls
);

  localparam int unsigned CNT_W = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);

  logic [CNT_W-1:0] starve_cnt_q;
  logic [CNT_W-1:0] starve_cnt_d;
  logic             if_starved;

  // Pick and counter update happen together; the counter only moves on a grant.
  always_comb begin
    starve_cnt_d = starve_cnt_q;
    if_starved   = if_req && (starve_cnt_q == CNT_W'(STARVE_MAX));
    sel_ls       = arb_en && ls_req && !if_starved;
    sel_if       = arb_en && if_req && !sel_ls;

    if (sel_ls && if_req) begin
      if (starve_cnt_q != CNT_W'(STARVE_MAX)) begin
        starve_cnt_d = starve_cnt_q + CNT_W'(1);
      end
    end else if (sel_if || sel_ls) begin
      starve_cnt_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      starve_cnt_q <= '0;
    end else begin
      starve_cnt_q <= starve_cnt_d;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Single-outstanding arbiter sharing one single-port memory between fetch and load/store;
// responses are routed back to whichever requester owns the transaction.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W     = ADDR_W_DEF,
  parameter int unsigned DATA_W     = DATA_W_DEF,
  parameter int unsigned STARVE_MAX = STARVE_MAX_DEF
) (
  input  logic                  clk,
  input  logic                  rst,

  input  logic                  if_req,
  input  logic [ADDR_W-1:0]     if_addr,
  output logic                  if_gnt,
  output logic                  if_rvalid,
  output logic [DATA_W-1:0]     if_rdata,

  input  logic                  ls_req,
  input  logic                  ls_we,
  input  logic [DATA_W/8-1:0]   ls_be,
  input  logic [ADDR_W-1:0]     ls_addr,
  input  logic [DATA_W-1:0]     ls_wdata,
  output logic                  ls_gnt,
  output logic                  ls_rvalid,
  output logic [DATA_W-1:0]     ls_rdata,

  output logic                  mem_req,
  output logic                  mem_we,
  output logic [DATA_W/8-1:0]   mem_be,
  output logic [ADDR_W-1:0]     mem_addr,
  output logic [DATA_W-1:0]     mem_wdata,
  input  logic                  mem_gnt,
  input  logic                  mem_rvalid,
  input  logic [DATA_W-1:0]     mem_rdata,

  output logic                  busy
);

  localparam int unsigned BE_W = DATA_W / 8;

  state_e              state_q,     state_d;
  owner_e              owner_q,     owner_d;
  logic                mem_req_q,   mem_req_d;
  logic                mem_we_q,    mem_we_d;
  logic [BE_W-1:0]     mem_be_q,    mem_be_d;
  logic [ADDR_W-1:0]   mem_addr_q,  mem_addr_d;
  logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
  logic [DATA_W-1:0]   if_rdata_q,  if_rdata_d;
  logic [DATA_W-1:0]   ls_rdata_q,  ls_rdata_d;

  logic arb_en;
  logic sel_if;
  logic sel_ls;
  logic rsp_hit;

  assign arb_en = (state_q == ST_IDLE);

  mem_arb_prio #(
    .STARVE_MAX (STARVE_MAX)
  ) u_prio (
    .clk    (clk),
    .rst    (rst),
    .arb_en (arb_en),
    .if_req (if_req),
    .ls_req (ls_req),
    .sel_if (sel_if),
    .sel_ls (sel_ls)
  );

  // Responses only count while a transaction is waiting for one; strays elsewhere are dropped.
  assign rsp_hit   = (state_q == ST_RSP) && mem_rvalid;
  assign if_rvalid = rsp_hit && (owner_q == OWN_IF);
  assign ls_rvalid = rsp_hit && (owner_q == OWN_LS);
  assign if_rdata  = if_rvalid ? mem_rdata : if_rdata_q;
  assign ls_rdata  = ls_rvalid ? mem_rdata : ls_rdata_q;

  assign if_gnt    = sel_if;
  assign ls_gnt    = sel_ls;
  assign busy      = (state_q != ST_IDLE);

  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_be    = mem_be_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_be_d    = mem_be_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    if_rdata_d  = if_rdata_q;
    ls_rdata_d  = ls_rdata_q;

    unique case (state_q)
      ST_IDLE: begin
        if (sel_ls) begin
          owner_d     = OWN_LS;
          mem_req_d   = 1'b1;
          mem_we_d    = ls_we;
          mem_be_d    = ls_be;
          mem_addr_d  = ls_addr;
          mem_wdata_d = ls_wdata;
          state_d     = ST_REQ;
        end else if (sel_if) begin
          owner_d     = OWN_IF;
          mem_req_d   = 1'b1;
          mem_we_d    = 1'b0;
          mem_be_d    = BE_W'(BE_ALL);
          mem_addr_d  = if_addr;
          mem_wdata_d = '0;
          state_d     = ST_REQ;
        end
      end

      ST_REQ: begin
        if (mem_gnt) begin
          mem_req_d = 1'b0;
          state_d   = ST_RSP;
        end
      end

      ST_RSP: begin
        if (mem_rvalid) begin
          if (owner_q == OWN_IF) begin
            if_rdata_d = mem_rdata;
          end else begin
            ls_rdata_d = mem_rdata;
          end
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      owner_q     <= OWN_IF;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_be_q    <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      if_rdata_q  <= '0;
      ls_rdata_q  <= '0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_be_q    <= mem_be_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      if_rdata_q  <= if_rdata_d;
      ls_rdata_q  <= ls_rdata_d;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: transaction-level reference model checked every cycle,
// a small responding memory, and hand-computed literal checks per scenario.
module tb_mem_arbiter;

  localparam int unsigned AW     = 32;
  localparam int unsigned DW     = 32;
  localparam int          STARVE = 4;

  logic          clk;
  logic          rst;
  logic          if_req;
  logic [AW-1:0] if_addr;
  logic          if_gnt;
  logic          if_rvalid;
  logic [DW-1:0] if_rdata;
  logic          ls_req;
  logic          ls_we;
  logic [3:0]    ls_be;
  logic [AW-1:0] ls_addr;
  logic [DW-1:0] ls_wdata;
  logic          ls_gnt;
  logic          ls_rvalid;
  logic [DW-1:0] ls_rdata;
  logic          mem_req;
  logic          mem_we;
  logic [3:0]    mem_be;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_gnt;
  logic          mem_rvalid;
  logic [DW-1:0] mem_rdata;
  logic          busy;

  mem_arbiter #(
    .ADDR_W     (AW),
    .DATA_W     (DW),
    .STARVE_MAX (STARVE)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .if_req     (if_req),
    .if_addr    (if_addr),
    .if_gnt     (if_gnt),
    .if_rvalid  (if_rvalid),
    .if_rdata   (if_rdata),
    .ls_req     (ls_req),
    .ls_we      (ls_we),
    .ls_be      (ls_be),
    .ls_addr    (ls_addr),
    .ls_wdata   (ls_wdata),
    .ls_gnt     (ls_gnt),
    .ls_rvalid  (ls_rvalid),
    .ls_rdata   (ls_rdata),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_be     (mem_be),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_gnt    (mem_gnt),
    .mem_rvalid (mem_rvalid),
    .mem_rdata  (mem_rdata),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Responder knobs, written by the stimulus thread only
  int   gnt_wait;
  int   rsp_wait;
  logic stray;

  logic [31:0] mem_arr [logic [31:0]];

  // Memory responder: grants after gnt_wait cycles, answers rsp_wait cycles after the grant
  initial begin
    logic [31:0] cur_addr;
    logic [31:0] cur_wdata;
    logic [31:0] nw;
    logic [3:0]  cur_be;
    logic        cur_we;
    int          pend;
    int          cnt;
    mem_gnt    = 1'b0;
    mem_rvalid = 1'b0;
    mem_rdata  = '0;
    pend       = 0;
    cnt        = 0;
    cur_addr   = '0;
    cur_wdata  = '0;
    cur_be     = '0;
    cur_we     = 1'b0;
    mem_arr[32'h100] = 32'h0050_0093;
    mem_arr[32'h300] = 32'h1122_3344;
    forever begin
      @(posedge clk);
      #2;
      mem_gnt    = 1'b0;
      mem_rvalid = 1'b0;
      if (rst) begin
        pend = 0;
        cnt  = 0;
      end else if (pend == 0) begin
        if (mem_req) begin
          if (cnt >= gnt_wait) begin
            mem_gnt   = 1'b1;
            cur_addr  = mem_addr;
            cur_wdata = mem_wdata;
            cur_be    = mem_be;
            cur_we    = mem_we;
            pend      = 1;
            cnt       = 0;
          end else begin
            cnt++;
          end
        end
      end else begin
        if (cnt >= rsp_wait) begin
          nw = mem_arr.exists(cur_addr) ? mem_arr[cur_addr] : 32'h0;
          mem_rdata = nw;
          if (cur_we) begin
            for (int b = 0; b < 4; b++) begin
              if (cur_be[b]) nw[8*b +: 8] = cur_wdata[8*b +: 8];
            end
            mem_arr[cur_addr] = nw;
            mem_rdata = 32'h0;
          end
          mem_rvalid = 1'b1;
          pend = 0;
          cnt  = 0;
        end else begin
          cnt++;
        end
      end
      if (stray) begin
        mem_rvalid = 1'b1;
        mem_rdata  = 32'hDEAD_0BAD;
      end
    end
  end

  int total;
  int bad;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model state: one outstanding transaction described at transaction level
  logic        m_busy;
  logic        m_acc;
  logic        m_own_ls;
  int          m_cnt;
  logic        m_we;
  logic [3:0]  m_be;
  logic [31:0] m_addr;
  logic [31:0] m_wdata;
  logic [31:0] m_if_rd;
  logic [31:0] m_ls_rd;
  logic        log_en;
  bit          glog[$];

  task automatic model_step();
    logic starved;
    logic e_ifg;
    logic e_lsg;
    logic e_ifv;
    logic e_lsv;
    logic [31:0] e_ifd;
    logic [31:0] e_lsd;
    starved = if_req && (m_cnt == STARVE);
    e_lsg   = !m_busy && ls_req && !starved;
    e_ifg   = !m_busy && if_req && !e_lsg;
    e_ifv   = m_busy && m_acc && mem_rvalid && !m_own_ls;
    e_lsv   = m_busy && m_acc && mem_rvalid && m_own_ls;
    e_ifd   = e_ifv ? mem_rdata : m_if_rd;
    e_lsd   = e_lsv ? mem_rdata : m_ls_rd;

    chk("busy",      64'(busy),      64'(m_busy));
    chk("if_gnt",    64'(if_gnt),    64'(e_ifg));
    chk("ls_gnt",    64'(ls_gnt),    64'(e_lsg));
    chk("if_rvalid", 64'(if_rvalid), 64'(e_ifv));
    chk("ls_rvalid", 64'(ls_rvalid), 64'(e_lsv));
    chk("if_rdata",  64'(if_rdata),  64'(e_ifd));
    chk("ls_rdata",  64'(ls_rdata),  64'(e_lsd));
    chk("mem_req",   64'(mem_req),   64'(m_busy && !m_acc));
    chk("mem_we",    64'(mem_we),    64'(m_we));
    chk("mem_be",    64'(mem_be),    64'(m_be));
    chk("mem_addr",  64'(mem_addr),  64'(m_addr));
    chk("mem_wdata", 64'(mem_wdata), 64'(m_wdata));

    if (log_en && if_gnt) glog.push_back(1'b1);
    if (log_en && ls_gnt) glog.push_back(1'b0);

    if (rst) begin
      m_busy = 0; m_acc = 0; m_own_ls = 0; m_cnt = 0;
      m_we = 0; m_be = '0; m_addr = '0; m_wdata = '0;
      m_if_rd = '0; m_ls_rd = '0;
    end else begin
      m_if_rd = e_ifd;
      m_ls_rd = e_lsd;
      if (!m_busy) begin
        if (e_lsg) begin
          m_busy = 1; m_acc = 0; m_own_ls = 1;
          m_we = ls_we; m_be = ls_be; m_addr = ls_addr; m_wdata = ls_wdata;
          m_cnt = if_req ? ((m_cnt < STARVE) ? m_cnt + 1 : STARVE) : 0;
        end else if (e_ifg) begin
          m_busy = 1; m_acc = 0; m_own_ls = 0;
          m_we = 0; m_be = 4'hF; m_addr = if_addr; m_wdata = '0;
          m_cnt = 0;
        end
      end else if (!m_acc) begin
        if (mem_gnt) m_acc = 1;
      end else if (mem_rvalid) begin
        m_busy = 0;
      end
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_rv(input string name, input bit is_ls, output logic [31:0] d);
    bit seen;
    seen = 1'b0;
    d    = '0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (is_ls ? ls_rvalid : if_rvalid) begin
        seen = 1'b1;
        d    = is_ls ? ls_rdata : if_rdata;
      end
    end
    chk(name, 64'(seen), 64'h1);
  endtask

  initial begin
    logic [31:0] d;
    logic [9:0]  seq;
    total = 0; bad = 0;
    rst = 1'b1; if_req = 0; if_addr = '0;
    ls_req = 0; ls_we = 0; ls_be = '0; ls_addr = '0; ls_wdata = '0;
    gnt_wait = 0; rsp_wait = 0; stray = 0; log_en = 0;
    m_busy = 0; m_acc = 0; m_own_ls = 0; m_cnt = 0;
    m_we = 0; m_be = '0; m_addr = '0; m_wdata = '0; m_if_rd = '0; m_ls_rd = '0;

    fork
      forever begin
        @(negedge clk);
        model_step();
      end
    join_none

    cyc(); cyc();
    @(negedge clk);
    chk("rst_busy",     64'(busy),     64'h0);
    chk("rst_mem_req",  64'(mem_req),  64'h0);
    chk("rst_if_rdata", 64'(if_rdata), 64'h0);
    cyc(); rst = 0;

    // Single fetch
    cyc(); if_req = 1; if_addr = 32'h100;
    @(negedge clk); chk("f_gnt", 64'(if_gnt), 64'h1);
    cyc(); if_req = 0;
    @(negedge clk);
    chk("f_addr", 64'(mem_addr), 64'h100);
    chk("f_be",   64'(mem_be),   64'hF);
    chk("f_we",   64'(mem_we),   64'h0);
    wait_rv("f_rv_seen", 0, d);
    chk("f_rdata", 64'(d), 64'h0050_0093);
    @(negedge clk); chk("f_rdata_hold", 64'(if_rdata), 64'h0050_0093);

    // Store then load of the same word
    cyc(); ls_req = 1; ls_we = 1; ls_be = 4'h3; ls_addr = 32'h2000; ls_wdata = 32'hBEEF;
    @(negedge clk); chk("st_gnt", 64'(ls_gnt), 64'h1);
    cyc(); ls_req = 0;
    @(negedge clk);
    chk("st_we",    64'(mem_we),    64'h1);
    chk("st_be",    64'(mem_be),    64'h3);
    chk("st_wdata", 64'(mem_wdata), 64'hBEEF);
    wait_rv("st_ack_seen", 1, d);
    cyc(); ls_req = 1; ls_we = 0; ls_be = 4'hF; ls_wdata = '0;
    @(negedge clk); chk("ld_gnt", 64'(ls_gnt), 64'h1);
    cyc(); ls_req = 0;
    wait_rv("ld_rv_seen", 1, d);
    chk("ld_rdata", 64'(d), 64'h0000_BEEF);

    // Back-pressure: grant withheld for five REQ cycles, with a stray response in the middle
    gnt_wait = 5;
    cyc(); if_req = 1; if_addr = 32'h300;
    @(negedge clk); chk("bp_gnt", 64'(if_gnt), 64'h1);
    cyc(); if_req = 0; ls_req = 1; ls_we = 0; ls_be = 4'hF; ls_addr = 32'h400;
    for (int k = 0; k < 5; k++) begin
      if (k > 0) cyc();
      stray = (k == 2);
      @(negedge clk);
      chk("bp_mem_req", 64'(mem_req),   64'h1);
      chk("bp_addr",    64'(mem_addr),  64'h300);
      chk("bp_busy",    64'(busy),      64'h1);
      chk("bp_no_gnt",  64'({if_gnt, ls_gnt, if_rvalid}), 64'h0);
    end
    cyc(); stray = 0; gnt_wait = 0;
    wait_rv("bp_rv_seen", 0, d);
    chk("bp_rdata", 64'(d), 64'h1122_3344);
    @(negedge clk); chk("bp_ls_gnt", 64'(ls_gnt), 64'h1);
    cyc(); ls_req = 0;
    wait_rv("bp_ls_rv_seen", 1, d);

    // Starvation: both requesters held; fetch wins every fifth grant
    cyc(); log_en = 1;
    if_req = 1; if_addr = 32'h500; ls_req = 1; ls_we = 0; ls_addr = 32'h600;
    for (int i = 0; i < 100 && glog.size() < 10; i++) @(negedge clk);
    chk("sv_count", 64'(glog.size() >= 10), 64'h1);
    cyc(); if_req = 0; ls_req = 0; log_en = 0;
    seq = '0;
    for (int i = 0; i < 10 && i < glog.size(); i++) seq[i] = glog[i];
    chk("sv_seq", 64'(seq), 64'h210);
    for (int i = 0; i < 12 && busy; i++) @(negedge clk);
    chk("sv_drain", 64'(busy), 64'h0);

    // Reset while waiting for a response, then a stray response afterwards
    rsp_wait = 20;
    cyc(); if_req = 1; if_addr = 32'h100;
    @(negedge clk); chk("rr_gnt", 64'(if_gnt), 64'h1);
    cyc(); if_req = 0;
    cyc();
    @(negedge clk); chk("rr_busy_pre", 64'(busy), 64'h1);
    cyc(); rst = 1;
    cyc(); rst = 0;
    @(negedge clk);
    chk("rr_busy",     64'(busy),     64'h0);
    chk("rr_mem_req",  64'(mem_req),  64'h0);
    chk("rr_mem_addr", 64'(mem_addr), 64'h0);
    chk("rr_if_rdata", 64'(if_rdata), 64'h0);
    chk("rr_ls_rdata", 64'(ls_rdata), 64'h0);
    cyc(); stray = 1;
    @(negedge clk); chk("rr_stray", 64'({if_rvalid, ls_rvalid, busy}), 64'h0);
    cyc(); stray = 0; rsp_wait = 0;
    cyc(); if_req = 1; if_addr = 32'h100;
    @(negedge clk); chk("rr_regnt", 64'(if_gnt), 64'h1);
    cyc(); if_req = 0;
    wait_rv("rr_rv_seen", 0, d);
    chk("rr_rdata", 64'(d), 64'h0050_0093);

    // Stray response in IDLE leaves everything untouched
    cyc(); stray = 1;
    @(negedge clk);
    chk("st_idle_rv",    64'({if_rvalid, ls_rvalid}), 64'h0);
    chk("st_idle_rdata", 64'(if_rdata), 64'h0050_0093);
    cyc(); stray = 0;
    @(negedge clk); chk("st_idle_busy", 64'(busy), 64'h0);

    cyc(); cyc();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
